// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder
//  Purpose  : Bit-serial WIDTH-bit adder with carry-in. One full-adder cell
//             and a carry flop consume one operand bit per clock, LSB first.
//             Start/busy/done handshake; S/COUT/OVF hold between operations.
//  Revision : 1.0  initial release
// ============================================================================
module serial_adder #(
   parameter int WIDTH = 8                // operand/sum width, 1..32
) (
   input  logic             clk_i,
   input  logic             rst_i,        // asynchronous, active-high
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic [WIDTH-1:0] s_o,
   output logic             cout_o,
   output logic             ovf_o,
   output logic             busy_o,
   output logic             done_o
);

   // Counter only needs to reach WIDTH-1; keep at least one bit for WIDTH=1.
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

   localparam logic [0:0] c_IDLE = 1'b0;
   localparam logic [0:0] c_RUN  = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             w_sum_bit;
   logic             w_carry_nxt;
   logic [WIDTH-1:0] w_res_nxt;

   // Full-adder cell on the current LSBs and the carry flop.
   always_comb begin
      w_sum_bit   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
      w_carry_nxt = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));
   end

   // The new sum bit enters at the MSB so after WIDTH shifts bit 0 is the LSB.
   generate
      if (WIDTH == 1) begin : g_res_one
         assign w_res_nxt = w_sum_bit;
      end else begin : g_res_wide
         assign w_res_nxt = {w_sum_bit, res_q[WIDTH-1:1]};
      end
   endgenerate

   // Next-state logic: accept in IDLE, one bit per cycle in RUN.
   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      s_d     = s_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         c_IDLE: begin
            if (start_i) begin
               a_sr_d  = a_i;
               b_sr_d  = b_i;
               carry_d = cin_i;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = c_RUN;
            end
         end
         c_RUN: begin
            a_sr_d  = a_sr_q >> 1;
            b_sr_d  = b_sr_q >> 1;
            carry_d = w_carry_nxt;
            res_d   = w_res_nxt;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == c_LAST) begin
               // carry_q is the carry into the MSB on this final step.
               s_d     = w_res_nxt;
               cout_d  = w_carry_nxt;
               ovf_d   = carry_q ^ w_carry_nxt;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = c_IDLE;
            end
         end
         default: begin
            state_d = c_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= c_IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign s_o    = s_q;
   assign cout_o = cout_q;
   assign ovf_o  = ovf_q;
   assign busy_o = busy_q;
   assign done_o = done_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder
//  Purpose  : Self-checking bench for serial_adder (WIDTH=8). A transaction
//             level model predicts BUSY/DONE/S/COUT/OVF every cycle; directed
//             cases pin both the model and the DUT to hand-computed values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_adder;

   localparam int W = 8;

   logic         clk_i   = 1'b0;
   logic         rst_i   = 1'b1;
   logic         start_i = 1'b0;
   logic [W-1:0] a_i     = '0;
   logic [W-1:0] b_i     = '0;
   logic         cin_i   = 1'b0;
   logic [W-1:0] s_o;
   logic         cout_o, ovf_o, busy_o, done_o;

   int total = 0;
   int bad   = 0;
   int n_done = 0;

   serial_adder #(.WIDTH(W)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (start_i),
      .a_i     (a_i),
      .b_i     (b_i),
      .cin_i   (cin_i),
      .s_o     (s_o),
      .cout_o  (cout_o),
      .ovf_o   (ovf_o),
      .busy_o  (busy_o),
      .done_o  (done_o)
   );

   always #5 clk_i = ~clk_i;

   // ---------------- transaction-level reference model ----------------
   logic         m_busy, m_done, m_cout, m_ovf;
   logic [W-1:0] m_s;
   int           m_left;
   logic [W-1:0] p_s;
   logic         p_cout, p_ovf;

   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         m_busy <= 1'b0; m_done <= 1'b0; m_s <= '0; m_cout <= 1'b0;
         m_ovf  <= 1'b0; m_left <= 0;
      end else begin
         m_done <= 1'b0;
         if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_busy <= 1'b0;
               m_done <= 1'b1;
               m_s    <= p_s;
               m_cout <= p_cout;
               m_ovf  <= p_ovf;
            end
         end else if (start_i) begin
            int u, sv;
            u  = int'(a_i) + int'(b_i) + int'(cin_i);
            sv = int'($signed(a_i)) + int'($signed(b_i)) + int'(cin_i);
            p_s    <= u[W-1:0];
            p_cout <= u[W];
            p_ovf  <= (sv > 127) || (sv < -128);
            m_busy <= 1'b1;
            m_left <= W;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison of all outputs against the model.
   always @(negedge clk_i) begin
      if (!rst_i)
         check("cycle {busy,done,cout,ovf,s}",
               {52'd0, busy_o, done_o, cout_o, ovf_o, s_o},
               {52'd0, m_busy, m_done, m_cout, m_ovf, m_s});
      if (done_o) n_done++;
   end

   task automatic tick();
      @(posedge clk_i);
      #2;
   endtask

   // Start one operation and check latency plus literal results.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic [W-1:0] es, input logic ec, input logic eo);
      int n;
      a_i = a; b_i = b; cin_i = c; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      n = 0;
      while (!done_o && n < 20) begin
         tick();
         n++;
      end
      check("latency", 64'(n), 64'(W));
      check("S", {56'd0, s_o}, {56'd0, es});
      check("COUT", {63'd0, cout_o}, {63'd0, ec});
      check("OVF", {63'd0, ovf_o}, {63'd0, eo});
      check("model S", {56'd0, m_s}, {56'd0, es});
      check("model COUT/OVF", {62'd0, m_cout, m_ovf}, {62'd0, ec, eo});
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      #1;
      check("reset outputs", {52'd0, busy_o, done_o, cout_o, ovf_o, s_o}, 64'd0);
      tick(); tick();
      rst_i = 1'b0;
      tick();

      // Directed arithmetic cases.
      run_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
      run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      run_op(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
      run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

      // START and operand changes during RUN must be ignored.
      d0 = n_done;
      a_i = 8'h10; b_i = 8'h20; cin_i = 1'b0; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      tick(); tick(); tick();
      a_i = 8'hFF; b_i = 8'hFF; cin_i = 1'b1; start_i = 1'b1;
      tick(); tick();
      start_i = 1'b0;
      for (int k = 0; k < 8; k++) tick();
      check("ignored START result", {56'd0, s_o}, 64'h30);
      check("single DONE", 64'(n_done - d0), 64'd1);

      // Asynchronous reset mid-operation.
      a_i = 8'h12; b_i = 8'h34; cin_i = 1'b0; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      check("busy before reset", {63'd0, busy_o}, 64'd1);
      #1 rst_i = 1'b1;
      #1;
      check("async reset outputs", {52'd0, busy_o, done_o, cout_o, ovf_o, s_o}, 64'd0);
      tick();
      rst_i = 1'b0;
      d0 = n_done;
      for (int k = 0; k < 12; k++) tick();
      check("no DONE after reset", 64'(n_done - d0), 64'd0);
      run_op(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);

      // Back-to-back with START held high.
      a_i = 8'h01; b_i = 8'h02; cin_i = 1'b0; start_i = 1'b1;
      tick();
      a_i = 8'hAA; b_i = 8'h55;
      for (int k = 1; k <= 17; k++) begin
         tick();
         if (k == 8)
            check("b2b first DONE", {55'd0, done_o, s_o}, {55'd0, 1'b1, 8'h03});
         if (k > 8 && k < 17)
            check("b2b S hold", {55'd0, busy_o, s_o}, {55'd0, 1'b1, 8'h03});
         if (k == 17)
            check("b2b second DONE", {54'd0, done_o, cout_o, s_o}, {54'd0, 1'b1, 1'b0, 8'hFF});
      end
      start_i = 1'b0;
      tick(); tick();

      // Randomized traffic; the compare process checks every cycle.
      d0 = n_done;
      for (int k = 0; k < 800; k++) begin
         start_i = ($urandom_range(3) == 0);
         a_i     = W'($urandom);
         b_i     = W'($urandom);
         cin_i   = 1'($urandom);
         tick();
      end
      start_i = 1'b0;
      for (int k = 0; k < 12; k++) tick();
      total++;
      if (n_done - d0 < 20) begin
         bad++;
         $display("FAIL random DONE count: got %0d expected >= 20", n_done - d0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
